// File: rtl/multdiv_seq.sv
// multdiv_seq
//   Sequential signed multiply / divide unit. A one-cycle start pulse latches
//   both operands. The unit then iterates for 32 cycles and pulses
//   data_resultRDY for one cycle with the result. Both operations work on
//   operand magnitudes and fix up the sign at the final step.
//
// Ports
//   clock           rising-edge system clock
//   reset           asynchronous, active-high reset
//   ctrl_MULT       start pulse for a signed multiply (wins over ctrl_DIV)
//   ctrl_DIV        start pulse for a signed divide
//   data_operandA   multiplicand / dividend, sampled only on a start edge
//   data_operandB   multiplier / divisor, sampled only on a start edge
//   data_result     product[31:0] or quotient, held until the next completion
//   data_exception  multiply overflow, divide overflow or divide-by-zero
//   data_resultRDY  one-cycle pulse marking the result valid
//   busy            high while an operation is iterating (pipeline stall)

module multdiv_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, next_state;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] operand_mag;
    logic        negate;

    logic        start;
    logic        last_step;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next, mul_final;
    logic        mul_exc;
    logic [32:0] div_shift, div_diff;
    logic [63:0] div_next;
    logic [31:0] div_q, div_res;
    logic        div_exc;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign last_step = (count == 6'd31);
    assign mag_a     = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign mag_b     = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A start pulse restarts the unit from any state.
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = ctrl_MULT ? MUL : DIV;
        end else begin
            case (state)
                MUL, DIV: if (last_step) next_state = DONE;
                DONE:     next_state = IDLE;
                default:  next_state = IDLE;
            endcase
        end
    end

    // Multiply step. acc holds {partial product, remaining multiplier bits}.
    // operand_mag holds the multiplicand magnitude. Each step conditionally
    // adds it into the high half and shifts the whole register right.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand_mag} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};
        mul_final = negate ? (~mul_next + 64'd1) : mul_next;
        mul_exc   = (mul_final[63:32] != {32{mul_final[31]}});
    end

    // Restoring divide step. acc holds {partial remainder, dividend/quotient}.
    // operand_mag holds the divisor magnitude. A zero divisor never borrows,
    // so the raw quotient is all ones. That case is overridden at the end.
    // The only unrepresentable quotient is +2^31 (0x80000000 / -1).
    always_comb begin
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, operand_mag};
        div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                 : {div_diff[31:0],  acc[30:0], 1'b1};
        div_q     = div_next[31:0];
        div_res   = negate ? (~div_q + 32'd1) : div_q;
        div_exc   = (operand_mag == 32'd0) || (!negate && div_q[31]);
    end

    // Datapath and result registers. Results change only on the final step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc            <= 64'd0;
            operand_mag    <= 32'd0;
            negate         <= 1'b0;
            count          <= 6'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
        end else if (start) begin
            negate      <= data_operandA[31] ^ data_operandB[31];
            operand_mag <= ctrl_MULT ? mag_a : mag_b;
            acc         <= {32'd0, ctrl_MULT ? mag_b : mag_a};
            count       <= 6'd0;
        end else if (state == MUL) begin
            acc <= mul_next;
            if (count != 6'd32) count <= count + 6'd1;
            if (last_step) begin
                data_result    <= mul_final[31:0];
                data_exception <= mul_exc;
            end
        end else if (state == DIV) begin
            acc <= div_next;
            if (count != 6'd32) count <= count + 6'd1;
            if (last_step) begin
                data_result    <= (operand_mag == 32'd0) ? 32'd0 : div_res;
                data_exception <= div_exc;
            end
        end
    end

    assign data_resultRDY = (state == DONE);
    assign busy           = (state == MUL) || (state == DIV);

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all other state changes occur on the rising edge of clock.
REQ-002 Port: clock  in  1  single system clock, rising-edge active.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: ctrl_MULT  in  1  one-cycle start pulse for a signed multiply, driven from the decode stage's isMult.
REQ-005 Port: ctrl_DIV  in  1  one-cycle start pulse for a signed divide, driven from the decode stage's isDiv.
REQ-006 Port: data_operandA  in  32  multiplicand or dividend, sampled only on a start edge.
REQ-007 Port: data_operandB  in  32  multiplier or divisor, sampled only on a start edge.
REQ-008 Port: data_result  out  32  low 32 bits of the product, or the quotient.
REQ-009 Port: data_exception  out  1  overflow or divide-by-zero flag for the current result.
REQ-010 Port: data_resultRDY  out  1  one-cycle pulse marking data_result and data_exception valid.
REQ-011 Port: busy  out  1  high while an operation is in progress; the pipeline uses it as a stall request.

Function
REQ-012 The block SHALL implement the states IDLE, MUL, DIV and DONE, with a 6-bit iteration counter.
REQ-013 Start event: a rising edge with ctrl_MULT=1 or ctrl_DIV=1, sampled in any state. On a start event the block SHALL:
- latch both operands;
- clear the counter;
- enter MUL or DIV.
REQ-014 If ctrl_MULT and ctrl_DIV are both 1 on the same edge, the multiply SHALL take priority and the divide request SHALL be ignored.
REQ-015 A start event during MUL, DIV or DONE SHALL abort the current operation with no RDY pulse for it, and begin the new operation.
REQ-016 Multiply SHALL be a signed two's-complement iterative multiply:
- one partial-product step per cycle;
- 32 cycles in total;
- data_result is product[31:0].
REQ-017 Multiply data_exception SHALL be 1 exactly when the full 64-bit signed product is not equal to the sign extension of product[31:0].
REQ-018 Divide SHALL be signed restoring or non-restoring division on operand magnitudes:
- 32 cycles;
- quotient truncated toward zero;
- quotient negated when operand signs differ;
- the remainder is discarded.
REQ-019 Divisor equal to 0 SHALL produce data_result=0x00000000 and data_exception=1, with the normal 32-cycle latency.
REQ-020 Dividend 0x80000000 with divisor 0xFFFFFFFF SHALL produce data_result=0x80000000 and data_exception=1.
REQ-021 Latency: data_resultRDY SHALL be 1 for exactly the one cycle that follows the 32nd rising edge after the start edge; the state then moves MUL/DIV -> DONE.
REQ-022 DONE SHALL move to IDLE on the next edge when no start event occurs.
REQ-023 data_result and data_exception SHALL be updated only at the transition into DONE, and SHALL hold their values until the next completion or reset.
REQ-024 busy SHALL be 1 in MUL and DIV (from the edge after the start edge through the 32nd edge), and 0 in IDLE and DONE.
REQ-025 Operand inputs SHALL be ignored on all edges other than start edges, so they may change freely mid-operation.
REQ-026 The counter SHALL never wrap; it saturates at 32 and is cleared on a start event.

Reset
REQ-027 While reset is 1, the block SHALL hold:
- state=IDLE, counter=0;
- data_result=0x00000000;
- data_exception=0, data_resultRDY=0, busy=0.
REQ-028 Reset asserted mid-operation SHALL abort the operation immediately; no RDY pulse SHALL follow for it.
REQ-029 The first start event accepted after reset is the one sampled on the first rising edge with reset=0.

Verification
REQ-030 ctrl_MULT pulse with A=7, B=0xFFFFFFFD -> busy=1 for 32 cycles, then RDY for 1 cycle with result 0xFFFFFFEB and exception 0.
REQ-031 ctrl_MULT with A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1, at the same latency.
REQ-032 ctrl_DIV with A=0xFFFFFFF9 (-7), B=2 -> result 0xFFFFFFFD, exception 0; then ctrl_DIV with A=5, B=0 -> result 0x00000000, exception 1.
REQ-033 Mid-operation events:
- ctrl_MULT, then reset asserted at cycle 10 -> all outputs 0 and no RDY pulse;
- a new ctrl_MULT after reset -> correct RDY 32 edges later.
REQ-034 Restart and priority:
- ctrl_MULT, then ctrl_DIV (A=100, B=7) at cycle 15 -> exactly one RDY, 32 edges after the DIV edge, with result 14;
- ctrl_MULT and ctrl_DIV asserted on the same edge -> the multiply result is returned.
